// File: rtl/iu_div_pkg.sv
// rtl/iu_div_pkg.sv - shared opcodes, state encoding, flag indices and saturation values for iu_divider
package iu_div_pkg;

    localparam logic [5:0] OP_UDIV   = 6'b001110;
    localparam logic [5:0] OP_SDIV   = 6'b001111;
    localparam logic [5:0] OP_UDIVCC = 6'b011110;
    localparam logic [5:0] OP_SDIVCC = 6'b011111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [31:0] SAT_UNSIGNED = 32'hFFFF_FFFF;
    localparam logic [31:0] SAT_POS      = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG      = 32'h8000_0000;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_UDIV) || (op == OP_SDIV) || (op == OP_UDIVCC) || (op == OP_SDIVCC);
    endfunction

endpackage

// File: rtl/iu_div_step.sv
// rtl/iu_div_step.sv - one restoring-division step: 33-bit trial subtract of {rem, msb} minus divisor
module iu_div_step
    import iu_div_pkg::*;
(
    input  logic [31:0] rem,
    input  logic        msb,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [31:0] shifted;
    logic [31:0] diff;
    logic        borrow;

    // The 33rd trial bit is rem[31]; when set, the trial cannot go negative and
    // the low 32 bits of the subtraction are the new remainder.
    assign shifted        = {rem[30:0], msb};
    assign {borrow, diff} = {1'b0, shifted} - {1'b0, divisor};
    assign q_bit          = rem[31] | ~borrow;
    assign rem_next       = q_bit ? diff : shifted;

endmodule

// File: rtl/iu_divider.sv
// rtl/iu_divider.sv - SPARC V8 UDIV/SDIV(cc) radix-2 restoring divider; IU_DIV_EARLY_OUT_EN enables early exit
module iu_divider
    import iu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic [3:0]  flags,
    output logic        icc_we,
    output logic        div_zero_trap
);

    state_t state;
    state_t next_state;

    // rem/shift/divisor first hold the raw Y/A/B, then their magnitudes after PREP
    logic [31:0] rem;
    logic [31:0] shift;
    logic [31:0] divisor;
    logic [4:0]  cnt;
    logic        is_signed;
    logic        is_cc;
    logic        neg;
    logic        zero;
    logic        ovf_hi;

    logic        accept;
    logic [63:0] dividend;
    logic [63:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic        zero_c;
    logic        ovf_hi_c;
    logic [31:0] rem_next;
    logic        q_bit;
    logic [31:0] fix_rd;
    logic        fix_v;
    logic [3:0]  fix_flags;

    assign accept = (state == ST_IDLE) && start && op_legal(op);

    assign dividend = {rem, shift};
    assign dvd_mag  = (is_signed && rem[31]) ? -dividend : dividend;
    assign dvs_mag  = (is_signed && divisor[31]) ? -divisor : divisor;
    assign zero_c   = (divisor == 32'd0);
    assign ovf_hi_c = (dvd_mag[63:32] >= dvs_mag);

    iu_div_step u_step (
        .rem      (rem),
        .msb      (shift[31]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_PREP;
            ST_PREP: begin
`ifdef IU_DIV_EARLY_OUT_EN
                if (zero_c || ovf_hi_c) next_state = ST_FIX;
                else                    next_state = ST_ITER;
`else
                next_state = ST_ITER;
`endif
            end
            ST_ITER: if (cnt == 5'd0) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        fix_rd = shift;
        fix_v  = 1'b0;
        if (!is_signed) begin
            fix_v = ovf_hi;
            if (ovf_hi) fix_rd = SAT_UNSIGNED;
        end else if (neg) begin
            // -2^31 is representable, so only quotients beyond it saturate
            if (ovf_hi || shift > SAT_NEG) begin
                fix_rd = SAT_NEG;
                fix_v  = 1'b1;
            end else begin
                fix_rd = -shift;
            end
        end else if (ovf_hi || shift > SAT_POS) begin
            fix_rd = SAT_POS;
            fix_v  = 1'b1;
        end
        fix_flags         = 4'b0000;
        fix_flags[FLAG_N] = fix_rd[31];
        fix_flags[FLAG_Z] = (fix_rd == 32'd0);
        fix_flags[FLAG_V] = fix_v;
        fix_flags[FLAG_C] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            shift     <= '0;
            divisor   <= '0;
            cnt       <= '0;
            is_signed <= 1'b0;
            is_cc     <= 1'b0;
            neg       <= 1'b0;
            zero      <= 1'b0;
            ovf_hi    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rem       <= Y;
                        shift     <= A;
                        divisor   <= B;
                        is_signed <= op[0];
                        is_cc     <= op[4];
                    end
                end
                ST_PREP: begin
                    rem     <= dvd_mag[63:32];
                    shift   <= dvd_mag[31:0];
                    divisor <= dvs_mag;
                    neg     <= is_signed & (rem[31] ^ divisor[31]);
                    zero    <= zero_c;
                    ovf_hi  <= ovf_hi_c;
                    cnt     <= 5'd31;
                end
                ST_ITER: begin
                    rem   <= rem_next;
                    shift <= {shift[30:0], q_bit};
                    cnt   <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done          <= 1'b0;
            icc_we        <= 1'b0;
            div_zero_trap <= 1'b0;
            rd            <= '0;
            flags         <= '0;
        end else begin
            done          <= (state == ST_FIX);
            icc_we        <= (state == ST_FIX) && is_cc && !zero;
            div_zero_trap <= (state == ST_FIX) && zero;
            if (state == ST_FIX && !zero) begin
                rd    <= fix_rd;
                flags <= fix_flags;
            end
        end
    end

endmodule

// File: tb/tb_iu_divider.sv
// tb/tb_iu_divider.sv - scoreboard bench for iu_divider with directed hand-computed vectors
module tb_iu_divider;

    localparam logic [5:0] UDIV   = 6'b001110;
    localparam logic [5:0] SDIV   = 6'b001111;
    localparam logic [5:0] UDIVCC = 6'b011110;
    localparam logic [5:0] SDIVCC = 6'b011111;
    localparam int LAT_FULL = 35;
`ifdef IU_DIV_EARLY_OUT_EN
    localparam int LAT_EARLY = 3;
`else
    localparam int LAT_EARLY = 35;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] rd;
    logic [3:0]  flags;
    logic        icc_we;
    logic        div_zero_trap;

    typedef struct {
        logic [31:0] rd;
        logic [3:0]  flags;
        logic        we;
        logic        trap;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    iu_divider dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .A             (a),
        .B             (b),
        .Y             (y),
        .busy          (busy),
        .done          (done),
        .rd            (rd),
        .flags         (flags),
        .icc_we        (icc_we),
        .div_zero_trap (div_zero_trap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pops one expectation; pulses outside done are errors
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rd", rd, mon_e.rd);
                    chk("flags", {28'd0, flags}, {28'd0, mon_e.flags});
                    chk("icc_we", {31'd0, icc_we}, {31'd0, mon_e.we});
                    chk("div_zero_trap", {31'd0, div_zero_trap}, {31'd0, mon_e.trap});
                    chk("latency_cycle", cyc, mon_e.due);
                    chk("busy_in_done", {31'd0, busy}, 32'd0);
                end
            end else begin
                chk("stray_pulse", {30'd0, icc_we, div_zero_trap}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [5:0] o, input logic [31:0] yy, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] erd, input logic [3:0] efl,
                         input logic ewe, input logic etrap, input int lat);
        exp_t e;
        op = o; y = yy; a = aa; b = bb; start = 1'b1;
        e.rd = erd; e.flags = efl; e.we = ewe; e.trap = etrap; e.due = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; y = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rd", rd, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op = 6'b001010; a = 32'd1; b = 32'd1; y = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_op_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);

        issue(UDIV,   32'd0,         32'd100,       32'd7,         32'd14,        4'b0000, 1'b0, 1'b0, LAT_FULL);
        wait_done(60);
        issue(UDIVCC, 32'd1,         32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1010, 1'b1, 1'b0, LAT_EARLY);
        wait_done(60);
        issue(SDIVCC, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 4'b1000, 1'b1, 1'b0, LAT_FULL);
        wait_done(60);
        issue(SDIV,   32'd0,         32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 4'b1000, 1'b0, 1'b0, LAT_FULL);
        wait_done(60);
        issue(SDIVCC, 32'd0,         32'd3,         32'd7,         32'd0,         4'b0100, 1'b1, 1'b0, LAT_FULL);
        wait_done(60);
        issue(SDIVCC, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b0010, 1'b1, 1'b0, LAT_FULL);
        wait_done(60);
        issue(SDIVCC, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h8000_0000, 4'b1000, 1'b1, 1'b0, LAT_FULL);
        wait_done(60);
        issue(UDIVCC, 32'd0,         32'd5,         32'd0,         32'h8000_0000, 4'b1000, 1'b0, 1'b1, LAT_EARLY);
        wait_done(60);
        @(negedge clk);

        op = UDIV; y = 32'd0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        repeat (40) @(negedge clk);

        issue(UDIV, 32'd0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 4'b0000, 1'b0, 1'b0, LAT_FULL);
        repeat (4) @(negedge clk);
        op = UDIVCC; y = 32'd0; a = 32'd10; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        repeat (40) @(negedge clk);
        chk("idle_after_ignored_start", {31'd0, busy}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
